// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin arbiter sharing one multiplier between two requesters
module mul_share_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] prod0,
    output logic [15:0] prod1,
    output logic        timeout_err,
    output logic        busy,
    output logic        owner,
    output logic        mul_start,
    output logic [15:0] mul_ip_BA,
    input  logic [15:0] mul_op_prod,
    input  logic        mul_ready
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [15:0] ip_q, ip_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        terr_q, terr_d;
    logic [15:0] prod0_q, prod0_d;
    logic [15:0] prod1_q, prod1_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        sel;

    // A lone request wins outright; a tie goes to whoever was not served last
    assign sel = (req0 & req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        ip_d    = ip_q;
        gnt_d   = 2'b00;
        done_d  = 2'b00;
        terr_d  = 1'b0;
        prod0_d = prod0_q;
        prod1_d = prod1_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    ip_d    = sel ? {b1, a1} : {b0, a0};
                    start_d = 1'b1;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    owner_d = sel;
                    cnt_d   = 16'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mul_ready) begin
                    prod0_d = owner_q ? prod0_q : mul_op_prod;
                    prod1_d = owner_q ? mul_op_prod : prod1_q;
                    done_d  = owner_q ? 2'b10 : 2'b01;
                    start_d = 1'b0;
                    last_d  = owner_q;
                    state_d = RELEASE;
                end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    done_d  = owner_q ? 2'b10 : 2'b01;
                    terr_d  = 1'b1;
                    start_d = 1'b0;
                    last_d  = owner_q;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RELEASE: state_d = mul_ready ? RELEASE : IDLE;
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            ip_q    <= 16'd0;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            terr_q  <= 1'b0;
            prod0_q <= 16'd0;
            prod1_q <= 16'd0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            ip_q    <= ip_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            prod0_q <= prod0_d;
            prod1_q <= prod1_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign done0       = done_q[0];
    assign done1       = done_q[1];
    assign timeout_err = terr_q;
    assign prod0       = prod0_q;
    assign prod1       = prod1_q;
    assign busy        = state_q != IDLE;
    assign owner       = owner_q;
    assign mul_start   = start_q;
    assign mul_ip_BA   = ip_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: table-driven check of arbitration, results, timeout and reset
module tb_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        gnt0, gnt1, done0, done1, timeout_err, busy, owner, mul_start;
    logic [15:0] prod0, prod1, mul_ip_BA;
    logic [15:0] mul_op_prod = '0;
    logic        mul_ready = 1'b0;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] exp_prod [2];

    typedef struct {
        logic        r0, r1;
        logic [7:0]  a0, b0, a1, b1;
        int          dly;
        logic [15:0] mp;
        logic        sel;
        logic [15:0] ip;
        int          wt;
    } vec_t;
    vec_t vt [9];

    mul_share_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .prod0(prod0), .prod1(prod1), .timeout_err(timeout_err),
        .busy(busy), .owner(owner), .mul_start(mul_start),
        .mul_ip_BA(mul_ip_BA), .mul_op_prod(mul_op_prod), .mul_ready(mul_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int w;
        req0 = v.r0; req1 = v.r1;
        a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(gnt0 | gnt1) && w < 10);
        chk("grant_wait", 32'(w), 32'(v.wt));
        chk("gnt0", 32'(gnt0), 32'(!v.sel));
        chk("gnt1", 32'(gnt1), 32'(v.sel));
        chk("owner", 32'(owner), 32'(v.sel));
        chk("ip_at_grant", 32'(mul_ip_BA), 32'(v.ip));
        chk("start_busy", 32'({mul_start, busy}), 32'(2'b11));
        for (int i = 0; i < v.dly; i++) begin
            @(negedge clk);
            a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
            chk("ip_hold", 32'(mul_ip_BA), 32'(v.ip));
            chk("busy_pulses", 32'({gnt0, gnt1, done0, done1, mul_start}), 32'(5'b00001));
        end
        mul_ready = 1'b1;
        mul_op_prod = v.mp;
        @(negedge clk);
        mul_ready = 1'b0;
        exp_prod[v.sel] = v.mp;
        chk("done", 32'({done1, done0}), v.sel ? 32'd2 : 32'd1);
        chk("timeout_err", 32'(timeout_err), 32'd0);
        chk("start_off", 32'({mul_start, gnt0, gnt1}), 32'd0);
        chk("prod0", 32'(prod0), 32'(exp_prod[0]));
        chk("prod1", 32'(prod1), 32'(exp_prod[1]));
    endtask

    initial begin
        int c;
        vt[0] = '{1'b1, 1'b1, 8'h03, 8'h05, 8'h07, 8'h09, 2, 16'h000F, 1'b0, 16'h0503, 1};
        vt[1] = '{1'b1, 1'b1, 8'h03, 8'h05, 8'h07, 8'h09, 3, 16'h003F, 1'b1, 16'h0907, 2};
        vt[2] = '{1'b1, 1'b1, 8'h11, 8'h02, 8'h00, 8'h00, 1, 16'h0022, 1'b0, 16'h0211, 2};
        vt[3] = '{1'b1, 1'b1, 8'h11, 8'h02, 8'h10, 8'h10, 5, 16'h0100, 1'b1, 16'h1010, 2};
        vt[4] = '{1'b1, 1'b1, 8'hFF, 8'h01, 8'h10, 8'h10, 0, 16'h00FF, 1'b0, 16'h01FF, 2};
        vt[5] = '{1'b1, 1'b1, 8'hFF, 8'h01, 8'hFF, 8'hFF, 7, 16'hFE01, 1'b1, 16'hFFFF, 2};
        vt[6] = '{1'b1, 1'b0, 8'h0C, 8'h0A, 8'hFF, 8'hFF, 4, 16'h0078, 1'b0, 16'h0A0C, 2};
        vt[7] = '{1'b0, 1'b1, 8'h0C, 8'h0A, 8'h80, 8'h02, 2, 16'h0100, 1'b1, 16'h0280, 2};
        vt[8] = '{1'b1, 1'b0, 8'h00, 8'h33, 8'h80, 8'h02, 1, 16'h0000, 1'b0, 16'h3300, 2};
        exp_prod[0] = '0;
        exp_prod[1] = '0;
        #3;
        chk("reset_flags", 32'({gnt0, gnt1, done0, done1, timeout_err, busy, owner, mul_start}), 32'd0);
        chk("reset_data", {prod0, prod1}, 32'd0);
        chk("reset_ip", 32'(mul_ip_BA), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        req0 = 1'b1;
        #2 req0 = 1'b0;
        @(negedge clk);
        chk("dropped_req", 32'({gnt0, gnt1, busy}), 32'd0);
        for (int i = 0; i < 9; i++) run_vec(vt[i]);
        // Timeout: requester 1 alone, multiplier never answers
        req0 = 1'b0; req1 = 1'b1; a1 = 8'h21; b1 = 8'h43;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!gnt1 && c < 10);
        chk("to_grant", 32'({gnt1, owner}), 32'(2'b11));
        chk("to_ip", 32'(mul_ip_BA), 32'h4321);
        req1 = 1'b0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done1 && c < 20);
        chk("to_latency", 32'(c), 32'd8);
        chk("to_flags", 32'({done1, done0, timeout_err, mul_start}), 32'(4'b1010));
        chk("to_prod1", 32'(prod1), 32'(exp_prod[1]));
        @(negedge clk);
        chk("to_idle", 32'({busy, done1, timeout_err}), 32'd0);
        // Reset mid-operation
        req1 = 1'b1; a1 = 8'h05; b1 = 8'h06;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!gnt1 && c < 10);
        chk("rst_grant", 32'(gnt1), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_flags", 32'({gnt0, gnt1, done0, done1, timeout_err, busy, owner, mul_start}), 32'd0);
        chk("rst_data", {prod0, prod1}, 32'd0);
        chk("rst_ip", 32'(mul_ip_BA), 32'd0);
        @(negedge clk);
        chk("rst_no_done", 32'({done0, done1}), 32'd0);
        exp_prod[0] = '0;
        exp_prod[1] = '0;
        reset = 1'b1;
        run_vec('{1'b0, 1'b1, 8'h00, 8'h00, 8'h05, 8'h06, 3, 16'h001E, 1'b1, 16'h0605, 1});
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_idle", 32'({busy, mul_start}), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of BUSY cycles to wait for mul_ready; legal range 1..65535.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0 and req1, input, 1 bit each: level request from requester 0 (UART path) and requester 1 (SPI path).
REQ-005 The block SHALL have ports a0, b0, a1 and b1, input, 8 bits each: operands A and B of each requester.
REQ-006 The block SHALL have ports gnt0 and gnt1, output, 1 bit each: a one-cycle pulse when that requester's operands are latched.
REQ-007 The block SHALL have ports done0 and done1, output, 1 bit each: a one-cycle pulse when that requester's result or error is valid.
REQ-008 The block SHALL have ports prod0 and prod1, output, 16 bits each: the registered result per requester, held until that requester's next done.
REQ-009 The block SHALL have port timeout_err, output, 1 bit: asserted together with done when the operation timed out.
REQ-010 The block SHALL have ports busy (output, 1 bit: state is not IDLE) and owner (output, 1 bit: index of the current or last granted requester).
REQ-011 The block SHALL have ports mul_start (output, 1 bit), mul_ip_BA (output, 16 bits, {B,A}), mul_op_prod (input, 16 bits) and mul_ready (input, 1 bit): the shared multiplier interface.

Function
REQ-012 The block SHALL implement the states IDLE, BUSY and RELEASE; it SHALL contain no other reachable states, and any illegal encoding SHALL go to IDLE.
REQ-013 IDLE, no request: the block SHALL stay in IDLE and hold mul_start at 0.
REQ-014 IDLE, with req0 or req1 high: on the next edge the block SHALL:
- latch mul_ip_BA = {b_sel, a_sel};
- set mul_start to 1;
- pulse gnt_sel;
- set owner to sel;
- clear the timeout counter;
- go to BUSY.
REQ-015 Arbitration SHALL be round-robin: a single request wins; with both high, the requester that is not the last-served one wins.
REQ-016 After reset, last-served SHALL be 1, so that requester 0 wins the first tie.
REQ-017 BUSY: mul_start SHALL stay at 1, and mul_ip_BA SHALL stay stable regardless of changes on a*/b*.
REQ-018 BUSY, with mul_ready high: on the next edge the block SHALL:
- load prod_owner with mul_op_prod;
- pulse done_owner;
- drive timeout_err to 0;
- drive mul_start to 0;
- update last-served to owner;
- go to RELEASE.
REQ-019 Result latency SHALL be one cycle from mul_ready sampled high to done high.
REQ-020 BUSY, with the counter equal to TIMEOUT_CYCLES-1 and mul_ready low: on the next edge the block SHALL:
- pulse done_owner and timeout_err;
- leave prod_owner unchanged;
- drive mul_start to 0;
- update last-served;
- go to RELEASE.
REQ-021 If mul_ready and the timeout occur in the same cycle, the ready path (REQ-018) SHALL win.
REQ-022 The timeout counter SHALL be 16 bits, SHALL increment by 1 per BUSY cycle, and SHALL NOT wrap (it is cleared on every grant).
REQ-023 RELEASE: the block SHALL stay in RELEASE while mul_ready is 1 and SHALL go to IDLE on the first cycle mul_ready is 0.
REQ-024 The minimum time between consecutive grants SHALL be 3 cycles: grant, then BUSY and RELEASE.
REQ-025 A request dropped in IDLE before grant SHALL be ignored.
REQ-026 A request dropped during BUSY SHALL NOT abort the operation: it completes and done is still pulsed.
REQ-027 A requester holding req high after its done SHALL be treated as a new request; the round-robin rule then gives the other requester priority if it is pending.
REQ-028 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously, and gnt and done SHALL never be high in the same cycle.

Reset
REQ-029 While reset is low, asynchronously, the block SHALL drive:
- state = IDLE;
- mul_start = 0 and mul_ip_BA = 0;
- gnt0, gnt1, done0, done1 and timeout_err = 0;
- prod0 and prod1 = 0;
- busy = 0 and owner = 0;
- last-served = 1;
- counter = 0.
REQ-030 Reset asserted mid-BUSY SHALL abandon the operation with no done pulse.
REQ-031 After reset is released, the first edge SHALL evaluate IDLE normally.

Verification
REQ-032 Single request: req0=1, a0=8'h0C, b0=8'h0A; model mul_ready 4 cycles after mul_start with mul_op_prod=16'h0078 -> gnt0 pulses, mul_ip_BA=16'h0A0C, done0 one cycle after ready, prod0=16'h0078, timeout_err=0.
REQ-033 Tie after reset: req0=req1=1 in the same cycle -> requester 0 is served first; requester 1 is granted immediately after RELEASE; owner goes 0 then 1.
REQ-034 Fairness: both requests held high for 6 operations -> grants alternate 0,1,0,1,0,1; there is no back-to-back grant to the same requester.
REQ-035 Timeout: TIMEOUT_CYCLES=8 and mul_ready never rises -> done1 and timeout_err pulse exactly 8 cycles after the grant, prod1 is unchanged, the block returns to IDLE.
REQ-036 Reset mid-operation: reset driven low 2 cycles into BUSY -> all outputs read 0 immediately; no done pulse; after release, req1 alone is granted normally.
REQ-037 Operand stability: a0/b0 changed every cycle during BUSY -> mul_ip_BA holds the value latched at grant until the next grant.
